// File: rtl/ysyx_23060077_ex_div_param.sv
// Iterative restoring divider: one quotient bit per cycle, signed or unsigned,
// with divide-by-zero and signed-overflow results resolved without iterating.
module ysyx_23060077_ex_div_param #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             div_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             flush,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

    state_t           state_reg;
    logic             signed_reg;
    logic             dvd_neg_reg;
    logic             dvs_neg_reg;
    logic             div_zero_reg;
    logic             ovf_reg;
    logic [WIDTH-1:0] dvd_orig_reg;
    logic [WIDTH-1:0] dvs_mag_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] quot_out_reg;
    logic [WIDTH-1:0] rem_out_reg;

    logic             dvd_neg_next;
    logic             dvs_neg_next;
    logic [WIDTH-1:0] dvd_mag_next;
    logic [WIDTH-1:0] dvs_mag_next;
    logic             div_zero_next;
    logic             ovf_next;
    logic [WIDTH:0]   trial;
    logic             trial_ge;
    logic [WIDTH-1:0] trial_diff;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] rem_next;

    // Operand decode at acceptance: signs, magnitudes and special cases.
    always_comb begin
        dvd_neg_next  = div_signed & dividend[WIDTH-1];
        dvs_neg_next  = div_signed & divisor[WIDTH-1];
        dvd_mag_next  = dvd_neg_next ? (~dividend + 1'b1) : dividend;
        dvs_mag_next  = dvs_neg_next ? (~divisor + 1'b1) : divisor;
        div_zero_next = (divisor == '0);
        ovf_next      = div_signed && (dividend == MIN_NEG) && (divisor == '1);
    end

    // One restoring step; the difference fits WIDTH bits whenever it is kept.
    always_comb begin
        trial      = {rem_reg, shift_reg[WIDTH-1]};
        trial_ge   = (trial >= {1'b0, dvs_mag_reg});
        trial_diff = trial[WIDTH-1:0] - dvs_mag_reg;
    end

    always_comb begin
        quot_next = shift_reg;
        rem_next  = rem_reg;
        if (div_zero_reg) begin
            quot_next = '1;
            rem_next  = dvd_orig_reg;
        end else if (ovf_reg) begin
            quot_next = dvd_orig_reg;
            rem_next  = '0;
        end else begin
            if (signed_reg && (dvd_neg_reg ^ dvs_neg_reg))
                quot_next = ~shift_reg + 1'b1;
            if (signed_reg && dvd_neg_reg)
                rem_next = ~rem_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            signed_reg   <= 1'b0;
            dvd_neg_reg  <= 1'b0;
            dvs_neg_reg  <= 1'b0;
            div_zero_reg <= 1'b0;
            ovf_reg      <= 1'b0;
            dvd_orig_reg <= '0;
            dvs_mag_reg  <= '0;
            shift_reg    <= '0;
            rem_reg      <= '0;
            cnt_reg      <= '0;
            quot_out_reg <= '0;
            rem_out_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (div_valid && !flush) begin
                        signed_reg   <= div_signed;
                        dvd_neg_reg  <= dvd_neg_next;
                        dvs_neg_reg  <= dvs_neg_next;
                        div_zero_reg <= div_zero_next;
                        ovf_reg      <= ovf_next;
                        dvd_orig_reg <= dividend;
                        dvs_mag_reg  <= dvs_mag_next;
                        shift_reg    <= dvd_mag_next;
                        rem_reg      <= '0;
                        cnt_reg      <= '0;
                        state_reg    <= (div_zero_next || ovf_next) ? FIXUP : CALC;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        // Dividend bits shift out the top while quotient bits enter the bottom.
                        shift_reg <= {shift_reg[WIDTH-2:0], trial_ge};
                        rem_reg   <= trial_ge ? trial_diff : trial[WIDTH-1:0];
                        cnt_reg   <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_ITER)
                            state_reg <= FIXUP;
                    end
                end
                FIXUP: begin
                    if (flush) begin
                        state_reg <= IDLE;
                    end else begin
                        quot_out_reg <= quot_next;
                        rem_out_reg  <= rem_next;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign div_ready = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign quotient  = quot_out_reg;
    assign remainder = rem_out_reg;

endmodule
